// File: rtl/census_wta_match.sv
// Census-domain stereo matcher: Hamming cost against MAX_DISP right-image candidates,
// then a registered winner-take-all tree that prefers the lowest disparity on ties.
module census_wta_match #(
    parameter int W        = 640,
    parameter int MAX_DISP = 16,
    parameter int DW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [24:0]   census_l,
    input  logic [24:0]   census_r,
    input  logic          census_valid,
    output logic [DW-1:0] disp_out,
    output logic [4:0]    min_cost,
    output logic          disp_valid
);

    localparam int LAT   = 1 + DW;
    localparam int NODES = 2 * MAX_DISP - 1;
    localparam int LEAF0 = MAX_DISP - 1;

    function automatic logic [4:0] popcount25(input logic [24:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 25; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    // Masked candidates take a cost above any real one (max 25) so they never win.
    function automatic logic [4:0] mask_cost(input logic [4:0] c, input logic masked);
        return masked ? 5'd31 : c;
    endfunction

    logic [9:0]  x_pos;
    logic [24:0] r_hist [MAX_DISP-1];
    logic [4:0]  cost_p0 [MAX_DISP];

    // Heap-ordered tree: node n has children 2n+1 (lower disparities) and 2n+2.
    // Leaves sit at LEAF0+d, so every level keeps disparities in index order.
    logic [4:0]    cost_tree [NODES];
    logic [DW-1:0] disp_tree [NODES];
    logic [LAT-1:0] vld_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            for (int i = 0; i < MAX_DISP - 1; i++) r_hist[i] <= '0;
        end else if (census_valid) begin
            x_pos     <= (x_pos == 10'(W - 1)) ? '0 : x_pos + 10'd1;
            r_hist[0] <= census_r;
            for (int i = 1; i < MAX_DISP - 1; i++) r_hist[i] <= r_hist[i-1];
        end
    end

    // Stage 0 -> 1: per-candidate Hamming cost with left-border masking
    always_comb begin
        for (int d = 0; d < MAX_DISP; d++) cost_p0[d] = 5'd31;
        cost_p0[0] = popcount25(census_l ^ census_r);
        for (int d = 1; d < MAX_DISP; d++)
            cost_p0[d] = mask_cost(popcount25(census_l ^ r_hist[d-1]), x_pos < 10'(d));
    end

    // Stages 2..1+DW: one tree level per clock, ties resolved toward the left child
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NODES; n++) begin
                cost_tree[n] <= '0;
                disp_tree[n] <= '0;
            end
            vld_p <= '0;
        end else begin
            for (int d = 0; d < MAX_DISP; d++) begin
                cost_tree[LEAF0 + d] <= cost_p0[d];
                disp_tree[LEAF0 + d] <= DW'(d);
            end
            for (int n = 0; n < LEAF0; n++) begin
                if (cost_tree[2*n+2] < cost_tree[2*n+1]) begin
                    cost_tree[n] <= cost_tree[2*n+2];
                    disp_tree[n] <= disp_tree[2*n+2];
                end else begin
                    cost_tree[n] <= cost_tree[2*n+1];
                    disp_tree[n] <= disp_tree[2*n+1];
                end
            end
            vld_p <= {vld_p[LAT-2:0], census_valid};
        end
    end

    assign disp_out   = disp_tree[0];
    assign min_cost   = cost_tree[0];
    assign disp_valid = vld_p[LAT-1];

endmodule

// File: tb/tb_census_wta_match.sv
// Directed bench for census_wta_match: a W=640 instance and a W=12 instance share one
// input stream; per-pixel expectations are queued and matched against outputs by cycle.
module tb_census_wta_match;

    localparam int LAT     = 5;
    localparam int T_ID    = 0;
    localparam int T_ONE   = 1;
    localparam int T_SHIFT = 2;

    typedef struct {
        int cyc;
        int d;
        int c;
        int mode;
        int x;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_na, rst_nb;
    logic [24:0] census_l, census_r;
    logic        census_valid;
    logic [3:0]  disp_a, disp_b;
    logic [4:0]  cost_a, cost_b;
    logic        dv_a, dv_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   xa = 0;
    int   xb = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    census_wta_match #(.W(640), .MAX_DISP(16), .DW(4)) dut_a (
        .clk(clk), .rst_n(rst_na), .census_l(census_l), .census_r(census_r),
        .census_valid(census_valid), .disp_out(disp_a), .min_cost(cost_a), .disp_valid(dv_a)
    );

    census_wta_match #(.W(12), .MAX_DISP(16), .DW(4)) dut_b (
        .clk(clk), .rst_n(rst_nb), .census_l(census_l), .census_r(census_r),
        .census_valid(census_valid), .disp_out(disp_b), .min_cost(cost_b), .disp_valid(dv_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Distinct pseudo-random vectors: odd multiplier is a bijection mod 2^25.
    function automatic logic [24:0] vec(input int i);
        logic [31:0] t;
        t = 32'(i) * 32'h00A5A5A7 + 32'h00123457;
        return t[24:0];
    endfunction

    function automatic exp_t mk(input int typ, input int x, input int c0);
        exp_t e;
        e.cyc = c0 + LAT; e.x = x; e.mode = 0; e.d = 0; e.c = 0;
        if (typ == T_ONE) e.c = 25;
        else if (typ == T_SHIFT) begin
            if (x >= 7) e.d = 7;
            else e.mode = 1;
        end
        return e;
    endfunction

    task automatic px(input int typ, input logic [24:0] l, input logic [24:0] r, input logic v);
        @(posedge clk);
        #1;
        census_l = l; census_r = r; census_valid = v;
        if (v) begin
            qa.push_back(mk(typ, xa, cyc));
            qb.push_back(mk(typ, xb, cyc));
            xa = (xa == 639) ? 0 : xa + 1;
            xb = (xb == 11) ? 0 : xb + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) px(T_ID, 25'($urandom), 25'($urandom), 1'b0);
    endtask

    task automatic chk_clear(input string tag, input logic [3:0] d, input logic [4:0] c,
                             input logic v);
        chk({tag, "_disp"}, int'(d), 0);
        chk({tag, "_cost"}, int'(c), 0);
        chk({tag, "_vld"}, int'(v), 0);
    endtask

    task automatic reset_all();
        idle(LAT + 2);
        @(posedge clk);
        #1;
        census_valid = 1'b0;
        rst_na = 1'b0; rst_nb = 1'b0;
        #2;
        chk_clear("rstall_a", disp_a, cost_a, dv_a);
        chk_clear("rstall_b", disp_b, cost_b, dv_b);
        qa.delete(); qb.delete();
        @(posedge clk);
        #1;
        rst_na = 1'b1; rst_nb = 1'b1;
        xa = 0; xb = 0;
    endtask

    task automatic shift_run(input int i0, input int n, input bit bubbles);
        for (int i = i0; i < i0 + n; i++) begin
            px(T_SHIFT, vec(i), vec(i + 7), 1'b1);
            if (bubbles) px(T_SHIFT, 25'($urandom), 25'($urandom), 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            chk("a_missed_vld", 0, 1);
            void'(qa.pop_front());
        end
        if (dv_a) begin
            if (qa.size() == 0) chk("a_spurious_vld", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("a_latency", cyc, ea.cyc);
                if (ea.mode == 0) begin
                    chk("a_disp", int'(disp_a), ea.d);
                    chk("a_cost", int'(cost_a), ea.c);
                end else chk("a_disp_le_x", int'(int'(disp_a) <= ea.x), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            chk("b_missed_vld", 0, 1);
            void'(qb.pop_front());
        end
        if (dv_b) begin
            if (qb.size() == 0) chk("b_spurious_vld", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("b_latency", cyc, eb.cyc);
                if (eb.mode == 0) begin
                    chk("b_disp", int'(disp_b), eb.d);
                    chk("b_cost", int'(cost_b), eb.c);
                end else chk("b_disp_le_x", int'(int'(disp_b) <= eb.x), 1);
            end
        end
    end

    initial begin
        census_l = '0; census_r = '0; census_valid = 1'b0;
        rst_na = 1'b0; rst_nb = 1'b0;

        // Held in reset with inputs toggling: outputs must stay cleared.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            census_l = 25'($urandom); census_r = 25'($urandom);
            census_valid = 1'($urandom);
            #3;
            chk_clear("hold_a", disp_a, cost_a, dv_a);
            chk_clear("hold_b", disp_b, cost_b, dv_b);
        end
        @(posedge clk);
        #1;
        census_valid = 1'b0;
        rst_na = 1'b1; rst_nb = 1'b1;
        idle(4);

        // Identical left/right over one full 640-pixel line.
        for (int i = 0; i < 640; i++) begin
            logic [24:0] r;
            r = 25'($urandom);
            px(T_ID, r, r, 1'b1);
        end

        // All-zero census, then all-ones left against zero right.
        reset_all();
        for (int i = 0; i < 20; i++) px(T_ID, 25'h0, 25'h0, 1'b1);
        for (int i = 0; i < 20; i++) px(T_ONE, 25'h1FFFFFF, 25'h0, 1'b1);

        // Right stream leads by 7, continuous then with 1,0 bubbles.
        reset_all();
        shift_run(0, 40, 1'b0);
        reset_all();
        shift_run(0, 40, 1'b1);

        // Three W=12 lines plus a partial line up to column 6, then reset only dut_b.
        reset_all();
        shift_run(100, 43, 1'b0);
        @(posedge clk);
        #1;
        census_valid = 1'b0;
        #1;
        chk("b_vld_before_rst", int'(dv_b), 1);
        rst_nb = 1'b0;
        #1;
        chk_clear("midrst_b", disp_b, cost_b, dv_b);
        qb.delete();
        xb = 0;
        @(posedge clk);
        #1;
        rst_nb = 1'b1;
        shift_run(143, 15, 1'b0);

        idle(LAT + 3);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
